// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: ifetch -> queue -> dispatch handshake bundle.
// slave = queue side, master = ifetch/dispatch environment side.
interface inst_fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            in_valid;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_npc;
  logic            in_ready;
  logic            out_valid;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_npc;
  logic            out_ready;
  logic            almost_full;
  logic [CW-1:0]   count;

  modport slave (
    input  flush, in_valid, in_inst,
    input  in_pc, in_npc, out_ready,
    output in_ready, out_valid, out_inst,
    output out_pc, out_npc, almost_full, count
  );

  modport master (
    output flush, in_valid, in_inst,
    output in_pc, in_npc, out_ready,
    input  in_ready, out_valid, out_inst,
    input  out_pc, out_npc, almost_full, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: circular fetch->decode decoupling FIFO with flush.
// Optional IFQ_BYPASS_EN: zero-latency pass-through when queue is empty.
module inst_fetch_queue #(
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 2,
  parameter int XLEN         = 32
) (
  input logic          clock,
  input logic          reset,
  inst_fetch_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
  } ifq_ent_t;

  ifq_ent_t        mem [DEPTH];
  ifq_ent_t        head_ent;
  ifq_ent_t        in_ent;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   cnt;
  logic            full;
  logic            empty;
  logic            byp;
  logic            push;
  logic            pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

`ifdef IFQ_BYPASS_EN
  assign byp = empty & ~q.flush & q.out_ready & reset;
`else
  assign byp = 1'b0;
`endif

  assign in_ent = '{
    inst: q.in_inst,
    pc:   q.in_pc,
    npc:  q.in_npc
  };
  assign head_ent = mem[head];

  // A bypassed instruction is consumed without touching storage.
  assign push = q.in_valid & ~full & ~q.flush & ~byp;
  assign pop  = ~empty & q.out_ready & ~q.flush;

  always_comb begin
    q.in_ready    = ~full;
    q.almost_full = (cnt >= CW'(AFULL_THRESH));
    q.count       = cnt;
    q.out_valid   = ~empty;
    q.out_inst    = head_ent.inst;
    q.out_pc      = head_ent.pc;
    q.out_npc     = head_ent.npc;
    if (byp) begin
      q.out_valid = q.in_valid;
      q.out_inst  = q.in_inst;
      q.out_pc    = q.in_pc;
      q.out_npc   = q.in_npc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (q.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[tail] <= in_ent;
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: scoreboard bench for inst_fetch_queue.
// Build with +define+IFQ_BYPASS_EN to exercise the bypass path.
module tb_inst_fetch_queue;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  inst_fetch_queue_if #(.XLEN(32), .DEPTH(8)) ifq ();

  inst_fetch_queue #(
    .DEPTH(8),
    .AFULL_THRESH(6),
    .XLEN(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .q(ifq)
  );

  ent_t sb[$];
  ent_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   saw_100 = 1'b0;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, obs, exp);
  endtask

  function automatic logic [31:0] inst_of(logic [31:0] pc);
    return {pc[15:0], 16'h0013} ^ 32'h5a5a_0000;
  endfunction

  task automatic drive(bit v, logic [31:0] pc,
                       bit ordy, bit fl);
    ifq.in_valid  = v;
    ifq.in_pc     = pc;
    ifq.in_npc    = pc + 32'd4;
    ifq.in_inst   = inst_of(pc);
    ifq.out_ready = ordy;
    ifq.flush     = fl;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    while (ifq.count != 0 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 64'(ifq.count), 64'd0);
    chk({tag, "_ov"}, 64'(ifq.out_valid), 64'd0);
  endtask

  // Model: enqueue on accepted push, compare on pop.
  always @(negedge clock) begin
    if (ifq.out_valid && ifq.out_pc == 32'h100)
      saw_100 = 1'b1;
    if (!reset || ifq.flush) begin
      sb.delete();
    end else begin
      if (ifq.in_valid && ifq.in_ready)
        sb.push_back('{inst: ifq.in_inst,
                       pc:   ifq.in_pc,
                       npc:  ifq.in_npc});
      if (ifq.out_valid && ifq.out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("out_pc", 64'(ifq.out_pc), 64'(mon_e.pc));
          chk("out_inst", 64'(ifq.out_inst),
              64'(mon_e.inst));
          chk("out_npc", 64'(ifq.out_npc), 64'(mon_e.npc));
        end
      end
    end
  end

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) tick();
    chk("rst_ov", 64'(ifq.out_valid), 64'd0);
    chk("rst_ir", 64'(ifq.in_ready), 64'd1);
    chk("rst_af", 64'(ifq.almost_full), 64'd0);
    chk("rst_cnt", 64'(ifq.count), 64'd0);
    reset = 1'b1;
    tick();

    // Fill with dispatch stalled.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
      tick();
      chk("fill_cnt", 64'(ifq.count), 64'(i + 1));
      chk("fill_af", 64'(ifq.almost_full),
          64'(i + 1 >= 6));
    end
    chk("full_ir", 64'(ifq.in_ready), 64'd0);
    drive(1'b1, 32'h20, 1'b0, 1'b0);
    tick();
    chk("full_hold", 64'(ifq.count), 64'd8);

    // Full with simultaneous pop: pop only.
    drive(1'b1, 32'h20, 1'b1, 1'b0);
    tick();
    chk("fullpp_cnt", 64'(ifq.count), 64'd7);
    chk("fullpp_ir", 64'(ifq.in_ready), 64'd1);
    tick();
    chk("pp_cnt", 64'(ifq.count), 64'd7);
    drain("fill_drain");

    // Wrap with steady occupancy of 3.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    for (int i = 3; i < 23; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      tick();
      chk("wrap_cnt", 64'(ifq.count), 64'd3);
    end
    drain("wrap_drain");

    // Flush drops queue and same-cycle push/pop.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    chk("pre_flush", 64'(ifq.count), 64'd4);
    drive(1'b1, 32'h100, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush_cnt", 64'(ifq.count), 64'd0);
    chk("flush_ov", 64'(ifq.out_valid), 64'd0);
    repeat (3) tick();
    chk("flush_idle", 64'(ifq.count), 64'd0);

    // Empty queue, push with dispatch ready.
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    @(negedge clock);
`ifdef IFQ_BYPASS_EN
    chk("byp_ov", 64'(ifq.out_valid), 64'd1);
    chk("byp_pc", 64'(ifq.out_pc), 64'h40);
`else
    chk("nobyp_ov", 64'(ifq.out_valid), 64'd0);
`endif
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
`ifdef IFQ_BYPASS_EN
    chk("byp_cnt", 64'(ifq.count), 64'd0);
    chk("byp_ov1", 64'(ifq.out_valid), 64'd0);
`else
    chk("nobyp_cnt", 64'(ifq.count), 64'd1);
    chk("nobyp_ov1", 64'(ifq.out_valid), 64'd1);
    chk("nobyp_pc", 64'(ifq.out_pc), 64'h40);
`endif
    tick();
    chk("byp_end", 64'(ifq.count), 64'd0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    chk("pre_rst", 64'(ifq.count), 64'd5);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst_cnt", 64'(ifq.count), 64'd0);
    chk("arst_ov", 64'(ifq.out_valid), 64'd0);
    chk("arst_ir", 64'(ifq.in_ready), 64'd1);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("post_cnt", 64'(ifq.count), 64'd0);
    chk("post_ov", 64'(ifq.out_valid), 64'd0);

    chk("sb_left", 64'(sb.size()), 64'd0);
    chk("no_0x100", 64'(saw_100), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
